adc_serial_reg_writer: RTL and testbench

- Serial control-port master for the ADC extended-control interface, directly downstream of the ADC power/calibration FSM.
- Accepts three level-held requests from the FSM:
  - Init: write the full register set.
  - DesEnable: set DES mode.
  - DesDisable: clear DES mode.
- Shifts 32-bit frames out on Sclk/Sdata/Select and pulses Done once the requested sequence completes.

---
 rtl/adc_serial_pkg.sv | 40 ++++
 rtl/adc_serial_shifter.sv | 89 ++++++++
 rtl/adc_serial_reg_writer.sv | 88 ++++++++
 tb/tb_adc_serial_reg_writer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_serial_pkg.sv
// Shared constants for the ADC extended-control serial writer: frame header,
// register map, init ROM, DES words and state encodings.
package adc_serial_pkg;

  localparam logic [11:0] HEADER = 12'h001;

  localparam logic [3:0] CFG     = 4'h1;
  localparam logic [3:0] OFFS_I  = 4'h2;
  localparam logic [3:0] FS_I    = 4'h3;
  localparam logic [3:0] CAL_ADJ = 4'h4;
  localparam logic [3:0] EXT_CFG = 4'h9;
  localparam logic [3:0] OFFS_Q  = 4'hA;
  localparam logic [3:0] FS_Q    = 4'hB;

  localparam logic [15:0] EXT_CFG_DES_ON  = 16'h81FF;
  localparam logic [15:0] EXT_CFG_DES_OFF = 16'h01FF;

  localparam int INIT_ROM_DEPTH = 6;

  // {ADDR, DATA} entries, written in this order after power-up.
  localparam logic [19:0] INIT_ROM [INIT_ROM_DEPTH] = '{
    {CFG,     16'hB2FF},
    {OFFS_I,  16'h007F},
    {FS_I,    16'h807F},
    {CAL_ADJ, 16'hDBFF},
    {OFFS_Q,  16'h007F},
    {FS_Q,    16'h807F}
  };

  typedef enum logic [2:0] {
    IDLE, LOAD, BIT_LOW, BIT_HIGH, TAIL, GAP, DONE, WAIT_RELEASE
  } state_t;

  typedef enum logic [1:0] {SEQ_INIT, SEQ_DES_ON, SEQ_DES_OFF} seq_t;

  function automatic logic [31:0] make_frame(input logic [19:0] entry);
    return {HEADER, entry};
  endfunction

endpackage

// File: rtl/adc_serial_shifter.sv
// Sends one 32-bit frame MSB first: LOAD, 32 Sclk periods, TAIL hold, GAP.
// A start seen on the last GAP cycle chains the next frame with no idle cycle.
module adc_serial_shifter
  import adc_serial_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        start,
  input  logic [31:0] frame,
  output logic        busy,
  output logic        frame_done,
  output logic        sclk,
  output logic        sdata,
  output logic        select
);

  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [4:0]        bit_idx;
  logic [31:0]       shreg;

  assign busy       = (state != IDLE);
  assign frame_done = (state == GAP) && (cnt == GAP_LAST);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      sclk    <= 1'b0;
      sdata   <= 1'b0;
      select  <= 1'b1;
    end else begin
      case (state)
        IDLE: if (start) begin
          select <= 1'b0;
          state  <= LOAD;
        end
        LOAD: begin
          shreg   <= frame;
          sdata   <= frame[31];
          bit_idx <= 5'd31;
          cnt     <= '0;
          state   <= BIT_LOW;
        end
        BIT_LOW: if (cnt == HALF_LAST) begin
          cnt   <= '0;
          sclk  <= 1'b1;
          state <= BIT_HIGH;
        end else cnt <= cnt + 1'b1;
        // Data only moves on the falling Sclk edge, so it is stable across the rise.
        BIT_HIGH: if (cnt == HALF_LAST) begin
          cnt  <= '0;
          sclk <= 1'b0;
          if (bit_idx != 5'd0) begin
            bit_idx <= bit_idx - 5'd1;
            shreg   <= {shreg[30:0], 1'b0};
            sdata   <= shreg[30];
            state   <= BIT_LOW;
          end else state <= TAIL;
        end else cnt <= cnt + 1'b1;
        TAIL: if (cnt == HALF_LAST) begin
          cnt    <= '0;
          select <= 1'b1;
          sdata  <= 1'b0;
          state  <= GAP;
        end else cnt <= cnt + 1'b1;
        GAP: if (cnt == GAP_LAST) begin
          cnt <= '0;
          if (start) begin
            select <= 1'b0;
            state  <= LOAD;
          end else state <= IDLE;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/adc_serial_reg_writer.sv
// Serial control-port master: picks a request, sequences its frames through
// the shifter, pulses Done once and waits for all requests to drop.
module adc_serial_reg_writer
  import adc_serial_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8,
  parameter int INIT_COUNT = INIT_ROM_DEPTH
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Init,
  input  logic DesEnable,
  input  logic DesDisable,
  output logic Sclk,
  output logic Sdata,
  output logic Select,
  output logic Done
);

  localparam int IDX_W = $clog2(INIT_COUNT + 1);

  // LOAD here stands for "sequence in flight"; the shifter owns per-frame timing.
  state_t            state;
  seq_t              seq;
  logic [IDX_W-1:0]  idx;
  logic              any_req, more, start, busy, frame_done;
  logic [19:0]       entry;

  assign any_req = Init | DesEnable | DesDisable;
  assign more    = (seq == SEQ_INIT) && (idx != IDX_W'(INIT_COUNT - 1));
  assign start   = ((state == IDLE) && any_req && !busy) ||
                   ((state == LOAD) && frame_done && more);

  always_comb begin
    case (seq)
      SEQ_INIT:    entry = INIT_ROM[idx];
      SEQ_DES_OFF: entry = {EXT_CFG, EXT_CFG_DES_OFF};
      default:     entry = {EXT_CFG, EXT_CFG_DES_ON};
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      seq   <= SEQ_DES_ON;
      idx   <= '0;
      Done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_req && !busy) begin
          idx   <= '0;
          seq   <= Init ? SEQ_INIT : (DesDisable ? SEQ_DES_OFF : SEQ_DES_ON);
          state <= LOAD;
        end
        LOAD: if (frame_done) begin
          if (more) idx <= idx + 1'b1;
          else      state <= DONE;
        end
        DONE: begin
          Done  <= 1'b1;
          state <= WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          Done <= 1'b0;
          if (!any_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  adc_serial_shifter #(
    .CLK_DIV    (CLK_DIV),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_shifter (
    .Clock      (Clock),
    .Reset      (Reset),
    .start      (start),
    .frame      (make_frame(entry)),
    .busy       (busy),
    .frame_done (frame_done),
    .sclk       (Sclk),
    .sdata      (Sdata),
    .select     (Select)
  );

endmodule

// File: tb/tb_adc_serial_reg_writer.sv
// Bench for adc_serial_reg_writer: a default instance and a CLK_DIV=2/GAP=1
// instance, decoded by a bus monitor and compared against a frame-level model.
module tb_adc_serial_reg_writer;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic [1:0] init_r = '0, den_r = '0, ddis_r = '0;
  logic [1:0] sclk_w, sdata_w, sel_w, done_w;
  int total = 0, bad = 0, cyc = 0;

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  adc_serial_reg_writer dut0 (
    .Clock(Clock), .Reset(Reset), .Init(init_r[0]), .DesEnable(den_r[0]),
    .DesDisable(ddis_r[0]), .Sclk(sclk_w[0]), .Sdata(sdata_w[0]),
    .Select(sel_w[0]), .Done(done_w[0]));

  adc_serial_reg_writer #(.CLK_DIV(2), .GAP_CYCLES(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .Init(init_r[1]), .DesEnable(den_r[1]),
    .DesDisable(ddis_r[1]), .Sclk(sclk_w[1]), .Sdata(sdata_w[1]),
    .Select(sel_w[1]), .Done(done_w[1]));

  // Expected register image, written out independently of the design package.
  logic [19:0] rom [6] = '{20'h1B2FF, 20'h2007F, 20'h3807F, 20'h4DBFF, 20'hA007F, 20'hB807F};
  localparam logic [19:0] DES_ON  = 20'h981FF;
  localparam logic [19:0] DES_OFF = 20'h901FF;

  function automatic int cdiv(input int d); return (d == 0) ? 4 : 2; endfunction
  function automatic int fper(input int d);
    return 1 + 64 * cdiv(d) + cdiv(d) + ((d == 0) ? 8 : 1);
  endfunction
  function automatic logic [31:0] wrd(input logic [19:0] e); return {12'h001, e}; endfunction
  function automatic int exp_n(input logic [2:0] m); return m[2] ? 6 : 1; endfunction
  function automatic logic [31:0] exp_w(input logic [2:0] m, input int i);
    if (m[2]) return wrd(rom[i]);
    return m[1] ? wrd(DES_OFF) : wrd(DES_ON);
  endfunction

  // Bus monitor: frames captured on Sclk rising edges while Select is low.
  logic [31:0] frm [2][64];
  int fall_t [2][64];
  int rise_t [2][64];
  int nfrm[2] = '{0, 0}, nbits[2] = '{0, 0}, npart[2] = '{0, 0}, ndone[2] = '{0, 0};
  int done_t[2] = '{0, 0}, last_rise[2] = '{0, 0}, cur_fall[2] = '{0, 0};
  int per_bad[2] = '{0, 0}, stab_bad[2] = '{0, 0}, stray[2] = '{0, 0};
  logic [31:0] acc[2];
  logic [1:0] psclk = '0, psdata = '0, psel = 2'b11, pdone = '0;

  always @(negedge Clock) begin
    for (int d = 0; d < 2; d++) begin
      if (done_w[d] && !pdone[d]) begin ndone[d]++; done_t[d] = cyc; end
      if (!sel_w[d] && psel[d]) begin nbits[d] = 0; cur_fall[d] = cyc; end
      if (sclk_w[d] && !psclk[d]) begin
        if (sel_w[d]) stray[d]++;
        else begin
          if (nbits[d] > 0 && cyc - last_rise[d] != 2 * cdiv(d)) per_bad[d]++;
          if (sdata_w[d] !== psdata[d]) stab_bad[d]++;
          acc[d] = {acc[d][30:0], sdata_w[d]};
          nbits[d]++;
          last_rise[d] = cyc;
        end
      end else if (sclk_w[d] && psclk[d] && sdata_w[d] !== psdata[d]) stab_bad[d]++;
      if (sel_w[d] && !psel[d]) begin
        if (nbits[d] == 32 && nfrm[d] < 64) begin
          frm[d][nfrm[d]] = acc[d];
          fall_t[d][nfrm[d]] = cur_fall[d];
          rise_t[d][nfrm[d]] = cyc;
          nfrm[d]++;
        end else npart[d]++;
      end
    end
    psclk = sclk_w; psdata = sdata_w; psel = sel_w; pdone = done_w;
  end

  task automatic tick(); @(negedge Clock); #1; endtask

  task automatic drive(input int d, input logic [2:0] m);
    init_r[d] = m[2]; ddis_r[d] = m[1]; den_r[d] = m[0];
  endtask

  task automatic wait_done(input int d, input int nd0, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (ndone[d] > nd0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({sel_w[d], sclk_w[d], sdata_w[d], done_w[d]} !== 4'b1000) begin
        $display("FAIL reset_state dut%0d got=%b want=1000", d, {sel_w[d], sclk_w[d], sdata_w[d], done_w[d]});
        bad++;
      end
    end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_des_enable();
    int e0, n0, nd0; bit ok;
    n0 = nfrm[0]; nd0 = ndone[0];
    drive(0, 3'b001); e0 = cyc + 1;
    wait_done(0, nd0, 400, ok);
    total++; if (!ok) begin $display("FAIL des_timeout got=no_done want=done"); bad++; end
    total++; if (done_t[0] - e0 !== 270) begin $display("FAIL des_latency got=%0d want=270", done_t[0] - e0); bad++; end
    total++; if (nfrm[0] - n0 !== 1) begin $display("FAIL des_frames got=%0d want=1", nfrm[0] - n0); bad++; end
    total++; if (frm[0][n0] !== wrd(DES_ON)) begin $display("FAIL des_word got=%h want=%h", frm[0][n0], wrd(DES_ON)); bad++; end
    total++; if (rise_t[0][n0] - e0 !== 261) begin $display("FAIL des_select_rise got=%0d want=261", rise_t[0][n0] - e0); bad++; end
    tick();
    total++; if (done_w[0] !== 1'b0) begin $display("FAIL des_done_width got=%b want=0", done_w[0]); bad++; end
    drive(0, 3'b000);
    repeat (5) tick();
    total++; if (ndone[0] - nd0 !== 1) begin $display("FAIL des_done_count got=%0d want=1", ndone[0] - nd0); bad++; end
  endtask

  task automatic test_init_hold();
    int e0, n0, nd0; bit ok;
    n0 = nfrm[0]; nd0 = ndone[0];
    drive(0, 3'b100); e0 = cyc + 1;
    wait_done(0, nd0, 2000, ok);
    total++; if (!ok) begin $display("FAIL init_timeout got=no_done want=done"); bad++; end
    total++; if (done_t[0] - e0 !== 6 * fper(0) + 1) begin $display("FAIL init_latency got=%0d want=%0d", done_t[0] - e0, 6 * fper(0) + 1); bad++; end
    total++; if (fall_t[0][n0] !== e0) begin $display("FAIL init_first_select got=%0d want=%0d", fall_t[0][n0], e0); bad++; end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (frm[0][n0+i] !== wrd(rom[i])) begin $display("FAIL init_word%0d got=%h want=%h", i, frm[0][n0+i], wrd(rom[i])); bad++; end
      if (i > 0) begin
        total++;
        if (fall_t[0][n0+i] - rise_t[0][n0+i-1] !== 8) begin
          $display("FAIL init_gap%0d got=%0d want=8", i, fall_t[0][n0+i] - rise_t[0][n0+i-1]); bad++;
        end
      end
    end
    repeat (700) tick();
    total++; if (nfrm[0] - n0 !== 6 || ndone[0] - nd0 !== 1) begin
      $display("FAIL init_no_retrigger got=frames%0d/done%0d want=6/1", nfrm[0] - n0, ndone[0] - nd0); bad++;
    end
    drive(0, 3'b000);
    repeat (3) tick();
  endtask

  task automatic test_all_three();
    int e0, n0, nd0; bit ok; logic [2:0] m;
    n0 = nfrm[0]; nd0 = ndone[0];
    drive(0, 3'b111);
    wait_done(0, nd0, 2000, ok);
    total++; if (!ok || nfrm[0] - n0 !== 6) begin $display("FAIL all3_frames got=%0d want=6", nfrm[0] - n0); bad++; end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (frm[0][n0+i] !== wrd(rom[i])) begin $display("FAIL all3_word%0d got=%h want=%h", i, frm[0][n0+i], wrd(rom[i])); bad++; end
    end
    drive(0, 3'b001);
    repeat (400) tick();
    total++; if (nfrm[0] - n0 !== 6 || ndone[0] - nd0 !== 1) begin
      $display("FAIL all3_held_ignored got=frames%0d/done%0d want=6/1", nfrm[0] - n0, ndone[0] - nd0); bad++;
    end
    drive(0, 3'b000);
    repeat (3) tick();
    m = 3'b001 << $urandom_range(0, 2);
    n0 = nfrm[0]; nd0 = ndone[0];
    drive(0, m); e0 = cyc + 1;
    wait_done(0, nd0, 2000, ok);
    total++; if (!ok || done_t[0] - e0 !== exp_n(m) * fper(0) + 1) begin
      $display("FAIL all3_rearm_latency req=%b got=%0d want=%0d", m, done_t[0] - e0, exp_n(m) * fper(0) + 1); bad++;
    end
    for (int i = 0; i < exp_n(m); i++) begin
      total++;
      if (frm[0][n0+i] !== exp_w(m, i)) begin $display("FAIL all3_rearm_word%0d got=%h want=%h", i, frm[0][n0+i], exp_w(m, i)); bad++; end
    end
    drive(0, 3'b000);
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    int e0, n0, nd0, np0; bit ok;
    n0 = nfrm[0]; nd0 = ndone[0]; np0 = npart[0];
    drive(0, 3'b100);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (nfrm[0] == n0 + 3 && nbits[0] == 15 && !sel_w[0]) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin $display("FAIL rst_mid_reach got=not_reached want=frame3_bit17"); bad++; end
    Reset = 1'b1; drive(0, 3'b000);
    tick();
    total++; if ({sel_w[0], sclk_w[0], sdata_w[0], done_w[0]} !== 4'b1000) begin
      $display("FAIL rst_mid_outputs got=%b want=1000", {sel_w[0], sclk_w[0], sdata_w[0], done_w[0]}); bad++;
    end
    Reset = 1'b0;
    repeat (300) tick();
    total++; if (ndone[0] !== nd0 || npart[0] - np0 !== 1 || nfrm[0] - n0 !== 3) begin
      $display("FAIL rst_mid_quiet got=done%0d/part%0d/frames%0d want=0/1/3", ndone[0] - nd0, npart[0] - np0, nfrm[0] - n0); bad++;
    end
    n0 = nfrm[0]; nd0 = ndone[0];
    drive(0, 3'b010); e0 = cyc + 1;
    wait_done(0, nd0, 400, ok);
    drive(0, 3'b000);
    total++; if (!ok || done_t[0] - e0 !== 270) begin $display("FAIL rst_mid_off_latency got=%0d want=270", done_t[0] - e0); bad++; end
    total++; if (frm[0][n0] !== wrd(DES_OFF) || nfrm[0] - n0 !== 1) begin
      $display("FAIL rst_mid_off_word got=%h want=%h", frm[0][n0], wrd(DES_OFF)); bad++;
    end
    repeat (3) tick();
  endtask

  task automatic test_small();
    int e0, n0, nd0; bit ok;
    n0 = nfrm[1]; nd0 = ndone[1];
    drive(1, 3'b001); e0 = cyc + 1;
    wait_done(1, nd0, 300, ok);
    drive(1, 3'b000);
    total++; if (!ok || done_t[1] - e0 !== 133) begin $display("FAIL small_latency got=%0d want=133", done_t[1] - e0); bad++; end
    total++; if (frm[1][n0] !== wrd(DES_ON)) begin $display("FAIL small_word got=%h want=%h", frm[1][n0], wrd(DES_ON)); bad++; end
    total++; if (rise_t[1][n0] - e0 !== 131) begin $display("FAIL small_select_rise got=%0d want=131", rise_t[1][n0] - e0); bad++; end
    total++; if (per_bad[1] !== 0 || stab_bad[1] !== 0) begin
      $display("FAIL small_sclk_timing got=period_err%0d/stab_err%0d want=0/0", per_bad[1], stab_bad[1]); bad++;
    end
    repeat (3) tick();
  endtask

  task automatic test_pulse();
    int e0, n0, nd0; bit ok;
    n0 = nfrm[0]; nd0 = ndone[0];
    drive(0, 3'b010); e0 = cyc + 1;
    tick();
    drive(0, 3'b000);
    wait_done(0, nd0, 400, ok);
    total++; if (!ok || done_t[0] - e0 !== 270) begin $display("FAIL pulse_latency got=%0d want=270", done_t[0] - e0); bad++; end
    total++; if (frm[0][n0] !== wrd(DES_OFF)) begin $display("FAIL pulse_word got=%h want=%h", frm[0][n0], wrd(DES_OFF)); bad++; end
    tick();
    n0 = nfrm[0]; nd0 = ndone[0];
    drive(0, 3'b001); e0 = cyc + 1;
    wait_done(0, nd0, 400, ok);
    drive(0, 3'b000);
    total++; if (!ok || fall_t[0][n0] !== e0) begin $display("FAIL pulse_back_to_idle got=%0d want=%0d", fall_t[0][n0], e0); bad++; end
    total++; if (frm[0][n0] !== wrd(DES_ON)) begin $display("FAIL pulse_next_word got=%h want=%h", frm[0][n0], wrd(DES_ON)); bad++; end
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    int e0, n0, nd0; bit ok; logic [2:0] m;
    for (int k = 0; k < 4; k++) begin
      m = 3'($urandom_range(1, 7));
      n0 = nfrm[1]; nd0 = ndone[1];
      drive(1, m); e0 = cyc + 1;
      repeat ($urandom_range(1, 60)) tick();
      drive(1, 3'b000);
      wait_done(1, nd0, 1500, ok);
      total++; if (!ok || done_t[1] - e0 !== exp_n(m) * fper(1) + 1) begin
        $display("FAIL b2b%0d_latency req=%b got=%0d want=%0d", k, m, done_t[1] - e0, exp_n(m) * fper(1) + 1); bad++;
      end
      total++; if (nfrm[1] - n0 !== exp_n(m)) begin $display("FAIL b2b%0d_frames got=%0d want=%0d", k, nfrm[1] - n0, exp_n(m)); bad++; end
      for (int i = 0; i < exp_n(m); i++) begin
        total++;
        if (frm[1][n0+i] !== exp_w(m, i)) begin $display("FAIL b2b%0d_word%0d got=%h want=%h", k, i, frm[1][n0+i], exp_w(m, i)); bad++; end
      end
      repeat ($urandom_range(1, 4)) tick();
    end
    total++; if (stray[0] !== 0 || stray[1] !== 0) begin $display("FAIL sclk_outside_select got=%0d/%0d want=0/0", stray[0], stray[1]); bad++; end
  endtask

  initial begin
    test_reset();
    test_des_enable();
    test_init_hold();
    test_all_three();
    test_reset_mid();
    test_small();
    test_pulse();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
